// File: rtl/fm7_bus_master_if.sv
// Host request/acknowledge port and FM-7 I/O bus pins of the bus-cycle initiator.
// Signal prefixes follow the initiator's view: i_ enters the master, o_ leaves it.
interface fm7_bus_master_if;
    logic        i_req;
    logic        i_we;
    logic [15:0] i_addr;
    logic [7:0]  i_wdata;
    logic        o_ack;
    logic [7:0]  o_rdata;
    logic        o_busy;

    logic        i_mrdyn;
    logic [7:0]  i_mdatain;
    logic        o_e;
    logic        o_q;
    logic [15:0] o_maddrbus;
    logic        o_rwbn;
    logic        o_rden;
    logic        o_wtqen;
    logic [7:0]  o_mdataout;
    logic        o_mdataoe;

    modport master (
        input  i_req, i_we, i_addr, i_wdata, i_mrdyn, i_mdatain,
        output o_ack, o_rdata, o_busy, o_e, o_q, o_maddrbus, o_rwbn,
               o_rden, o_wtqen, o_mdataout, o_mdataoe
    );

    modport slave (
        output i_req, i_we, i_addr, i_wdata, i_mrdyn, i_mdatain,
        input  o_ack, o_rdata, o_busy, o_e, o_q, o_maddrbus, o_rwbn,
               o_rden, o_wtqen, o_mdataout, o_mdataoe
    );
endinterface

// File: rtl/fm7_bus_master.sv
// FM-7 main-CPU I/O bus initiator: E/Q quadrature by clock-enable division, one
// host read/write per bus cycle, idle cycles are strobe-less dummy reads of $FFFF.
module fm7_bus_master #(
    parameter int DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fm7_bus_master_if.master  bus
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        PH_Q0 = 2'd0,
        PH_Q1 = 2'd1,
        PH_Q2 = 2'd2,
        PH_Q3 = 2'd3
    } phase_t;

    logic [CNT_W-1:0] r_cnt;
    phase_t           r_phase;
    logic             r_boot;
    logic             r_host;
    logic             r_we;
    logic [7:0]       r_wdata;
    logic             r_e;
    logic             r_q;
    logic [15:0]      r_maddr;
    logic             r_rwbn;
    logic             r_rden;
    logic             r_wtqen;
    logic [7:0]       r_mdataout;
    logic             r_mdataoe;
    logic [7:0]       r_rdata;
    logic             r_ack;
    logic             r_busy;

    logic             w_quarter_end;
    logic             w_boundary;
    logic             w_stretch;
    logic             w_complete;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;
    phase_t           w_phase_nxt;
    logic             w_host_nxt;
    logic             w_we_nxt;
    logic [7:0]       w_wdata_nxt;
    logic             w_e_nxt;
    logic             w_q_nxt;
    logic [15:0]      w_maddr_nxt;
    logic             w_rwbn_nxt;
    logic             w_rden_nxt;
    logic             w_wtqen_nxt;
    logic [7:0]       w_mdataout_nxt;
    logic             w_mdataoe_nxt;
    logic [7:0]       w_rdata_nxt;
    logic             w_ack_nxt;
    logic             w_busy_nxt;

    // r_boot makes the first edge after reset behave like the end of a Q3,
    // so a fresh bus cycle (and a possible acceptance) starts right there.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_quarter_end  = (r_cnt == CNT_MAX);
        w_boundary     = r_boot || (w_quarter_end && (r_phase == PH_Q3));
        w_stretch      = w_quarter_end && (r_phase == PH_Q2) && !bus.i_mrdyn;
        w_complete     = w_boundary && r_host;
        w_accept       = w_boundary && bus.i_req && !w_complete;

        w_cnt_nxt      = (r_boot || w_quarter_end) ? '0 : r_cnt + CNT_W'(1);
        w_phase_nxt    = r_phase;
        w_host_nxt     = r_host;
        w_we_nxt       = r_we;
        w_wdata_nxt    = r_wdata;
        w_maddr_nxt    = r_maddr;
        w_rwbn_nxt     = r_rwbn;
        w_rden_nxt     = r_rden;
        w_wtqen_nxt    = r_wtqen;
        w_mdataout_nxt = r_mdataout;
        w_mdataoe_nxt  = r_mdataoe;
        w_rdata_nxt    = r_rdata;
        w_ack_nxt      = w_complete;
        w_busy_nxt     = r_busy;

        if (r_boot) begin
            w_phase_nxt = PH_Q0;
        end else if (w_quarter_end && !w_stretch) begin
            case (r_phase)
                PH_Q0:   w_phase_nxt = PH_Q1;
                PH_Q1:   w_phase_nxt = PH_Q2;
                PH_Q2:   w_phase_nxt = PH_Q3;
                default: w_phase_nxt = PH_Q0;
            endcase
        end

        w_e_nxt = (w_phase_nxt == PH_Q2) || (w_phase_nxt == PH_Q3);
        w_q_nxt = (w_phase_nxt == PH_Q1) || (w_phase_nxt == PH_Q2);

        if (w_boundary) begin
            w_host_nxt    = w_accept;
            w_maddr_nxt   = w_accept ? bus.i_addr : 16'hFFFF;
            w_rwbn_nxt    = w_accept ? !bus.i_we : 1'b1;
            w_rden_nxt    = 1'b1;
            w_wtqen_nxt   = 1'b1;
            w_mdataoe_nxt = 1'b0;
            if (w_accept) begin
                w_we_nxt    = bus.i_we;
                w_wdata_nxt = bus.i_wdata;
                w_busy_nxt  = 1'b1;
            end
            if (w_complete && !r_we) begin
                w_rdata_nxt = bus.i_mdatain;
            end
        end else if (w_quarter_end && r_host) begin
            case (r_phase)
                PH_Q0: begin
                    if (r_we) begin
                        w_mdataout_nxt = r_wdata;
                        w_mdataoe_nxt  = 1'b1;
                    end
                end
                PH_Q1: begin
                    if (r_we) begin
                        w_wtqen_nxt = 1'b0;
                    end else begin
                        w_rden_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // busy covers the ack clock and drops on the edge after it
        if (r_ack) begin
            w_busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            r_cnt      <= '0;
            r_phase    <= PH_Q0;
            r_boot     <= 1'b1;
            r_host     <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= 8'h00;
            r_e        <= 1'b0;
            r_q        <= 1'b0;
            r_maddr    <= 16'hFFFF;
            r_rwbn     <= 1'b1;
            r_rden     <= 1'b1;
            r_wtqen    <= 1'b1;
            r_mdataout <= 8'h00;
            r_mdataoe  <= 1'b0;
            r_rdata    <= 8'h00;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_boot     <= 1'b0;
            r_host     <= w_host_nxt;
            r_we       <= w_we_nxt;
            r_wdata    <= w_wdata_nxt;
            r_e        <= w_e_nxt;
            r_q        <= w_q_nxt;
            r_maddr    <= w_maddr_nxt;
            r_rwbn     <= w_rwbn_nxt;
            r_rden     <= w_rden_nxt;
            r_wtqen    <= w_wtqen_nxt;
            r_mdataout <= w_mdataout_nxt;
            r_mdataoe  <= w_mdataoe_nxt;
            r_rdata    <= w_rdata_nxt;
            r_ack      <= w_ack_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.o_e        = r_e;
    assign bus.o_q        = r_q;
    assign bus.o_maddrbus = r_maddr;
    assign bus.o_rwbn     = r_rwbn;
    assign bus.o_rden     = r_rden;
    assign bus.o_wtqen    = r_wtqen;
    assign bus.o_mdataout = r_mdataout;
    assign bus.o_mdataoe  = r_mdataoe;
    assign bus.o_rdata    = r_rdata;
    assign bus.o_ack      = r_ack;
    assign bus.o_busy     = r_busy;

endmodule

// File: doc/fm7_bus_master.md
# fm7_bus_master

Synchronous bus-cycle initiator for the FM-7 main-CPU I/O bus. It drives 6809-style E/Q quadrature clocks, address, R/W and the read/write data-enable strobes (RDEn, WTQEn) that the $FD00–$FD3F I/O decoder consumes. A simple req/ack port lets a host such as a test sequencer, debugger or DMA engine issue single read or write cycles. One sys-clock domain; E/Q are derived by clock-enable division, not by a separate clock.

## Interface
- DIV, 4: sys clocks per E/Q quarter phase (≥2); one bus cycle = 4·DIV clocks.
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- req  in  1  host request; held high until ack.
- we  in  1  1 = write, 0 = read; sampled with req at acceptance.
- addr  in  16  host address; sampled at acceptance.
- wdata  in  8  write data; sampled at acceptance.
- ack  out  1  one-clock pulse; transaction complete, rdata valid for reads.
- rdata  out  8  read data; held until next read completes.
- busy  out  1  high from acceptance through the ack clock.
- MRDYn  in  1  slave ready, active-low stretch; low at end of Q2 extends E high.
- MDATAIN  in  8  bus data from slaves.
- E  out  1  6809 E clock.
- Q  out  1  6809 Q clock (leads E by one quarter).
- MADDRBUS  out  16  bus address.
- RWBn  out  1  1 = read, 0 = write.
- RDEn  out  1  read data enable, active-low.
- WTQEn  out  1  write strobe, active-low.
- MDATAOUT  out  8  write data to bus.
- MDATAOE  out  1  write data drive enable.

## Operation
- Quarter counter cnt counts 0..DIV-1. Phase register steps Q0→Q1→Q2→Q3→Q0 when cnt = DIV-1.
- E/Q per phase: Q0 E=0,Q=0; Q1 E=0,Q=1; Q2 E=1,Q=1; Q3 E=1,Q=0. E and Q are registered outputs.
- Cycle boundary is the edge ending Q3 (cnt = DIV-1, phase Q3). The first edge after reset release counts as a boundary.
- Acceptance happens on a boundary edge when req=1 and no ack is issued on that edge. It latches addr, we, wdata and sets busy. That cycle is then a host cycle.
- A host cycle takes 1 bus cycle, so consecutive requests are separated by at least one idle bus cycle.
- Idle cycle: MADDRBUS=16'hFFFF, RWBn=1, RDEn=1, WTQEn=1, MDATAOE=0. This is a dummy read with no strobes.
- Host read cycle: MADDRBUS=addr and RWBn=1 from Q0 start. RDEn=0 throughout Q2 and Q3.
- Host write cycle: MADDRBUS=addr and RWBn=0 from Q0 start. MDATAOUT=wdata and MDATAOE=1 from Q1 start to cycle end. WTQEn=0 throughout Q2 and Q3.
- Stretch: on the edge ending Q2, if MRDYn=0 the block stays in Q2 and cnt restarts at 0. E, Q and strobes hold. The stretch continues in whole quarters until MRDYn=1 at a Q2 end. It applies to idle cycles too. There is no timeout.
- Completion: on the host-cycle boundary edge, a read loads rdata←MDATAIN. ack=1 for that one clock. busy clears on the following edge.
- Outputs return to idle values at the next Q0 start.

## Timing
- Reset values: E=0, Q=0, phase Q0, cnt=0, MADDRBUS=FFFF, RWBn=1, RDEn=1, WTQEn=1, MDATAOUT=00, MDATAOE=0, rdata=00, ack=0, busy=0.
- Latency, with DIV=4 and no stretch: accept edge → ack edge = 16 clocks.
- Each MRDYn-low quarter adds DIV clocks.
- rdata is sampled at E falling, i.e. the last clock of Q3, using the MDATAIN value present on that edge.
- Changes to req, addr, we or wdata after acceptance are ignored.
- If req drops before acceptance, nothing is issued. If req drops mid-cycle, the cycle still completes and ack is still pulsed.
- If req is still high on the ack edge, it is not re-accepted. The host must deassert req on the clock after ack, or a second transaction is accepted at the next boundary.
- Reset mid-cycle: all state returns to reset values on that edge. No ack is issued, and rdata keeps 00 (reset value).

## Test plan
- Reset, then idle for 3 bus cycles → E/Q period 16 clks (DIV=4), Q leads E by 4 clks, MADDRBUS=FFFF, RDEn=WTQEn=1 throughout.
- Read addr=FD04, MDATAIN=5A → RDEn low for 8 clks during E high, ack 16 clks after accept, rdata=5A, RWBn=1.
- Write addr=FD0F, wdata=C3 → RWBn=0, MDATAOE=1 from Q1, WTQEn low 8 clks, MDATAOUT=C3, ack, rdata unchanged.
- Read FD00 with MRDYn low for 2 quarters at Q2 end → E high for 16 clks, ack at 24 clks, rdata captured at final edge.
- req held high across ack (back-to-back) → exactly one idle cycle (MADDRBUS=FFFF) between the two host cycles, no duplicate issue.
- Assert reset during Q2 of a write → next clock WTQEn=1, MDATAOE=0, E=0, busy=0, no ack pulse.
